// File: rtl/mod_n_counter_pkg.sv
// Shared timekeeping constants and the per-edge operation decode for mod_n_counter.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package mod_n_counter_pkg;

  // Standard moduli and register widths for clock stages
  localparam int unsigned MOD_SEC  = 60;
  localparam int unsigned MOD_MIN  = 60;
  localparam int unsigned MOD_HR24 = 24;
  localparam int unsigned MOD_HR12 = 12;
  localparam int unsigned MOD_DAY  = 7;
  localparam int unsigned W_SEC    = 6;
  localparam int unsigned W_HR     = 5;
  localparam int unsigned W_DAY    = 3;

  // What a single clock edge does to the counter, already priority-resolved
  typedef enum logic [2:0] {
    OP_HOLD,    // disabled, or Up/Dn both equal
    OP_LOAD,    // in-range load
    OP_REJECT,  // out-of-range load: keep count, raise LD_ERR
    OP_UP,
    OP_DN
  } op_e;

  // Priority: Enable, then LD, then a single Up or Dn request
  function automatic op_e decode_op(input logic enable, input logic ld,
                                    input logic up, input logic dn,
                                    input logic ld_ok);
    op_e op;
    op = OP_HOLD;
    if (!enable)        op = OP_HOLD;
    else if (ld)        op = ld_ok ? OP_LOAD : OP_REJECT;
    else if (up && !dn) op = OP_UP;
    else if (dn && !up) op = OP_DN;
    return op;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with range-checked load, wrap pulses and combinational TC for cascading.
// Latency: COUNT/CARRY/BORROW/LD_ERR update one edge after sampling; TC is same-cycle combinational.
// Backpressure: none; Enable=0 freezes the count and clears the wrap pulses.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int unsigned MOD     = MOD_DAY,
  parameter int unsigned W       = W_DAY,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         Enable,
  input  logic         LD,
  input  logic         Up,
  input  logic         Dn,
  input  logic [W-1:0] D,
  output logic [W-1:0] COUNT,
  output logic         TC,
  output logic         CARRY,
  output logic         BORROW,
  output logic         LD_ERR
);

  localparam logic [W-1:0] MAX_V = W'(MOD - 1);
  localparam logic [W-1:0] RST_V = W'(RST_VAL);

  // Refuse to build a counter that cannot hold its modulus or reset value
  generate
    if (((64'd1 << W) < 64'(MOD)) || (RST_VAL >= MOD) || (MOD < 2)) begin : g_param_err
      $fatal(1, "mod_n_counter: bad parameters MOD=%0d W=%0d RST_VAL=%0d", MOD, W, RST_VAL);
    end
  endgenerate

  logic at_max;
  logic at_zero;
  logic ld_ok;
  op_e  op;

  assign at_max  = (COUNT == MAX_V);
  assign at_zero = (COUNT == '0);
  assign ld_ok   = (D <= MAX_V);

  // Resolve input priority into a single operation for this edge
  always_comb begin
    op = decode_op(Enable, LD, Up, Dn, ld_ok);
  end

  // Terminal count: this edge will wrap, so the next stage may step with us
  assign TC = ((op == OP_UP) && at_max) || ((op == OP_DN) && at_zero);

  // Count state and flags; wrap pulses default low so they last one cycle
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      COUNT  <= RST_V;
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
      LD_ERR <= 1'b0;
    end else begin
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
      case (op)
        OP_LOAD: begin
          COUNT  <= D;
          LD_ERR <= 1'b0;
        end
        OP_REJECT: begin
          LD_ERR <= 1'b1;
        end
        OP_UP: begin
          if (at_max) begin
            COUNT <= '0;
            CARRY <= 1'b1;
          end else begin
            COUNT <= COUNT + 1'b1;
          end
        end
        OP_DN: begin
          if (at_zero) begin
            COUNT  <= MAX_V;
            BORROW <= 1'b1;
          end else begin
            COUNT <= COUNT - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: weekday (MOD=7, RST=3), hours (MOD=24) and a cascaded pair of MOD=60 stages.
// Directed scenarios followed by random stimulus, all checked against an integer reference model.
// Stage 3 can take its Enable from stage 2's TC to exercise cascading.
module tb_mod_n_counter;

  logic Clk;
  logic Clr;
  logic [3:0] en, ld, up, dn;
  logic [7:0] d [4];
  logic cascade;
  logic en_b;

  logic [2:0] c7;
  logic [4:0] c24;
  logic [5:0] c60a, c60b;
  logic [3:0] tc, carry, borrow, lderr;

  assign en_b = cascade ? tc[2] : en[3];

  mod_n_counter #(.MOD(7), .W(3), .RST_VAL(3)) u7 (
    .Clk(Clk), .Clr(Clr), .Enable(en[0]), .LD(ld[0]), .Up(up[0]), .Dn(dn[0]),
    .D(d[0][2:0]), .COUNT(c7), .TC(tc[0]), .CARRY(carry[0]), .BORROW(borrow[0]), .LD_ERR(lderr[0]));
  mod_n_counter #(.MOD(24), .W(5), .RST_VAL(0)) u24 (
    .Clk(Clk), .Clr(Clr), .Enable(en[1]), .LD(ld[1]), .Up(up[1]), .Dn(dn[1]),
    .D(d[1][4:0]), .COUNT(c24), .TC(tc[1]), .CARRY(carry[1]), .BORROW(borrow[1]), .LD_ERR(lderr[1]));
  mod_n_counter #(.MOD(60), .W(6), .RST_VAL(0)) u60a (
    .Clk(Clk), .Clr(Clr), .Enable(en[2]), .LD(ld[2]), .Up(up[2]), .Dn(dn[2]),
    .D(d[2][5:0]), .COUNT(c60a), .TC(tc[2]), .CARRY(carry[2]), .BORROW(borrow[2]), .LD_ERR(lderr[2]));
  mod_n_counter #(.MOD(60), .W(6), .RST_VAL(0)) u60b (
    .Clk(Clk), .Clr(Clr), .Enable(en_b), .LD(ld[3]), .Up(up[3]), .Dn(dn[3]),
    .D(d[3][5:0]), .COUNT(c60b), .TC(tc[3]), .CARRY(carry[3]), .BORROW(borrow[3]), .LD_ERR(lderr[3]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain integer state per instance
  typedef struct {
    int cnt;
    bit carry;
    bit borrow;
    bit lderr;
  } model_t;

  model_t m [4];
  int modv [4] = '{7, 24, 60, 60};
  int rstv [4] = '{3, 0, 0, 0};
  int wv   [4] = '{3, 5, 6, 6};

  int passed = 0;
  int total  = 0;

  function automatic model_t step(model_t s, int mod, bit e, bit l, bit u, bit dw, int dv);
    model_t n;
    n = s;
    n.carry  = 1'b0;
    n.borrow = 1'b0;
    if (!e) return n;
    if (l) begin
      if (dv < mod) begin
        n.cnt   = dv;
        n.lderr = 1'b0;
      end else begin
        n.lderr = 1'b1;
      end
      return n;
    end
    if (u && !dw) begin
      n.carry = (s.cnt == mod - 1);
      n.cnt   = (s.cnt + 1) % mod;
    end else if (dw && !u) begin
      n.borrow = (s.cnt == 0);
      n.cnt    = (s.cnt + mod - 1) % mod;
    end
    return n;
  endfunction

  // TC means: the step taken on the coming edge wraps
  function automatic bit wraps(int i, bit e);
    model_t n;
    n = step(m[i], modv[i], e, ld[i], up[i], dn[i], int'(d[i]));
    return n.carry | n.borrow;
  endfunction

  function automatic bit eff_en(int i);
    if (i == 3 && cascade) return wraps(2, en[2]);
    return en[i];
  endfunction

  function automatic logic [7:0] get_q(int i);
    case (i)
      0: return {5'b0, c7};
      1: return {3'b0, c24};
      2: return {2'b0, c60a};
      default: return {2'b0, c60b};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d.count", i),  32'(get_q(i)),   32'(m[i].cnt));
      check($sformatf("u%0d.carry", i),  32'(carry[i]),   32'(m[i].carry));
      check($sformatf("u%0d.borrow", i), 32'(borrow[i]),  32'(m[i].borrow));
      check($sformatf("u%0d.ld_err", i), 32'(lderr[i]),   32'(m[i].lderr));
      check($sformatf("u%0d.tc", i),     32'(tc[i]),      32'(wraps(i, eff_en(i))));
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) m[i] = '{rstv[i], 1'b0, 1'b0, 1'b0};
  endtask

  // Advance the model with the inputs presented at this edge, then compare
  task automatic tick();
    model_t nxt [4];
    for (int i = 0; i < 4; i++)
      nxt[i] = step(m[i], modv[i], eff_en(i), ld[i], up[i], dn[i], int'(d[i]));
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) m[i] = nxt[i];
    check_all();
  endtask

  task automatic drive(int i, bit e, bit l, bit u, bit dw, int dv);
    en[i] = e;
    ld[i] = l;
    up[i] = u;
    dn[i] = dw;
    d[i]  = 8'(dv);
  endtask

  initial begin
    Clr = 1'b1;
    cascade = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 0, 0, 0, 0, 0);
    reset_model();

    // Power-on reset
    #1 Clr = 1'b0;
    #2;
    check("reset.u7count", 32'(c7), 32'd3);
    check_all();
    @(negedge Clk);
    Clr = 1'b1;

    // T1: set LD_ERR, count to 5, then asynchronous clear between edges
    drive(0, 1, 1, 0, 0, 7);
    tick();
    check("T1.lderr_set", 32'(lderr[0]), 32'd1);
    drive(0, 1, 0, 1, 0, 0);
    tick();
    tick();
    check("T1.count5", 32'(c7), 32'd5);
    drive(0, 0, 0, 0, 0, 0);
    #2 Clr = 1'b0;
    #1;
    reset_model();
    check("T1.async_count", 32'(c7), 32'd3);
    check("T1.async_lderr", 32'(lderr[0]), 32'd0);
    check_all();
    #2 Clr = 1'b1;

    // T2: up-count 0..59, TC at 59, single-cycle CARRY on wrap
    drive(2, 1, 0, 1, 0, 0);
    repeat (59) tick();
    check("T2.count59", 32'(c60a), 32'd59);
    check("T2.tc59", 32'(tc[2]), 32'd1);
    tick();
    check("T2.wrap0", 32'(c60a), 32'd0);
    check("T2.carry", 32'(carry[2]), 32'd1);
    tick();
    check("T2.carry_drop", 32'(carry[2]), 32'd0);
    check("T2.count1", 32'(c60a), 32'd1);
    drive(2, 0, 0, 0, 0, 0);

    // T3: down-wrap on hours
    drive(1, 1, 0, 0, 1, 0);
    tick();
    check("T3.count23", 32'(c24), 32'd23);
    check("T3.borrow", 32'(borrow[1]), 32'd1);
    tick();
    check("T3.count22", 32'(c24), 32'd22);
    check("T3.borrow_drop", 32'(borrow[1]), 32'd0);
    drive(1, 0, 0, 0, 0, 0);

    // T4: valid load, rejected load, sticky error, clearing load
    drive(2, 1, 1, 0, 0, 45);
    tick();
    check("T4.load45", 32'(c60a), 32'd45);
    check("T4.lderr0", 32'(lderr[2]), 32'd0);
    drive(2, 1, 1, 0, 0, 61);
    tick();
    check("T4.hold45", 32'(c60a), 32'd45);
    check("T4.lderr1", 32'(lderr[2]), 32'd1);
    drive(2, 1, 0, 1, 0, 0);
    repeat (10) tick();
    check("T4.count55", 32'(c60a), 32'd55);
    check("T4.lderr_sticky", 32'(lderr[2]), 32'd1);
    drive(2, 1, 1, 0, 0, 0);
    tick();
    check("T4.load0", 32'(c60a), 32'd0);
    check("T4.lderr_clr", 32'(lderr[2]), 32'd0);

    // T5: load beats count, Up=Dn holds, Enable=0 beats load
    drive(2, 1, 1, 0, 0, 59);
    tick();
    drive(2, 1, 1, 1, 0, 10);
    #1;
    check("T5.tc_ld", 32'(tc[2]), 32'd0);
    tick();
    check("T5.load10", 32'(c60a), 32'd10);
    check("T5.no_carry", 32'(carry[2]), 32'd0);
    drive(2, 1, 0, 1, 1, 0);
    tick();
    check("T5.updn_hold", 32'(c60a), 32'd10);
    drive(2, 0, 1, 0, 0, 20);
    tick();
    check("T5.en0_hold", 32'(c60a), 32'd10);

    // T6: 59:59 -> 00:00 in one edge through TC chaining
    drive(2, 1, 1, 0, 0, 59);
    drive(3, 1, 1, 0, 0, 59);
    tick();
    cascade = 1'b1;
    drive(2, 1, 0, 1, 0, 0);
    drive(3, 0, 0, 1, 0, 0);
    #1;
    check("T6.tc_a", 32'(tc[2]), 32'd1);
    check("T6.tc_b", 32'(tc[3]), 32'd1);
    tick();
    check("T6.a0", 32'(c60a), 32'd0);
    check("T6.b0", 32'(c60b), 32'd0);
    check("T6.carry_a", 32'(carry[2]), 32'd1);
    check("T6.carry_b", 32'(carry[3]), 32'd1);
    tick();
    check("T6.a1", 32'(c60a), 32'd1);
    check("T6.b_hold", 32'(c60b), 32'd0);
    check("T6.carry_b_drop", 32'(carry[3]), 32'd0);
    cascade = 1'b0;

    // Random traffic on all stages, cascade toggled at random
    for (int k = 0; k < 400; k++) begin
      cascade = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        en[i] = ($urandom_range(0, 9) != 0);
        ld[i] = ($urandom_range(0, 9) == 0);
        up[i] = 1'($urandom_range(0, 1));
        dn[i] = 1'($urandom_range(0, 1));
        d[i]  = 8'($urandom_range(0, (1 << wv[i]) - 1));
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
